// File: rtl/pkt_proc_mvc.sv
// Multi-VC packet processor: TX frames AXI beats into HEAD/BODY/TAIL flits per VC,
// RX strips flit type, tracks packet boundaries per VC and registers through a 2-entry skid.
module pkt_proc_mvc #(
  parameter int NUM_VC      = 3,
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_SZ_W    = 8,
  parameter int SZ_LSB      = 0,
  localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                     clk_axi,
  input  logic                     arst_axi,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  input  logic [VC_W-1:0]          tx_vc_i,
  input  logic [PKT_SZ_W-1:0]      tx_pkt_sz_i,
  input  logic [FLIT_DATA_W-1:0]   tx_data_i,
  output logic                     noc_tx_valid_o,
  input  logic                     noc_tx_ready_i,
  output logic [VC_W-1:0]          noc_tx_vc_o,
  output logic [FLIT_DATA_W+1:0]   noc_tx_flit_o,
  input  logic                     noc_rx_valid_i,
  output logic                     noc_rx_ready_o,
  input  logic [VC_W-1:0]          noc_rx_vc_i,
  input  logic [FLIT_DATA_W+1:0]   noc_rx_flit_i,
  output logic                     rx_valid_o,
  input  logic                     rx_ready_i,
  output logic [VC_W-1:0]          rx_vc_o,
  output logic [FLIT_DATA_W-1:0]   rx_data_o,
  output logic                     rx_sop_o,
  output logic                     rx_eop_o,
  output logic [NUM_VC-1:0]        rx_err_o,
  input  logic [NUM_VC-1:0]        err_clr_i
);

  typedef enum logic [1:0] {TY_HEAD = 2'b00, TY_BODY = 2'b01, TY_TAIL = 2'b10, TY_RSVD = 2'b11} flit_ty_e;
  typedef enum logic {ST_IDLE, ST_PKT} vc_st_e;
  typedef struct packed {
    logic [VC_W-1:0]        vc;
    logic [FLIT_DATA_W-1:0] data;
    logic                   sop;
    logic                   eop;
  } skid_ent_t;

  localparam logic [PKT_SZ_W-1:0] SZ_ONE = PKT_SZ_W'(1);

  vc_st_e                tx_st_q  [NUM_VC];
  vc_st_e                tx_st_d  [NUM_VC];
  logic [PKT_SZ_W-1:0]   tx_cnt_q [NUM_VC];
  logic [PKT_SZ_W-1:0]   tx_cnt_d [NUM_VC];
  vc_st_e                rx_st_q  [NUM_VC];
  vc_st_e                rx_st_d  [NUM_VC];
  logic [PKT_SZ_W-1:0]   rx_rem_q [NUM_VC];
  logic [PKT_SZ_W-1:0]   rx_rem_d [NUM_VC];
  logic [NUM_VC-1:0]     err_q, err_d, err_set;
  skid_ent_t             sk0_q, sk0_d, sk1_q, sk1_d, in_ent;
  logic [1:0]            sk_cnt_q, sk_cnt_d;
  logic                  rdy_q, rdy_d;

  flit_ty_e              tx_ty, rx_ty;
  logic                  tx_vc_ok, rx_vc_ok, push, pop, in_sop, in_eop, in_err;
  logic [PKT_SZ_W-1:0]   rx_sz;

  assign tx_vc_ok       = 32'(tx_vc_i) < 32'(NUM_VC);
  assign noc_tx_valid_o = tx_valid_i;
  assign noc_tx_vc_o    = tx_vc_i;
  assign tx_ready_o     = noc_tx_ready_i;
  assign noc_tx_flit_o  = tx_valid_i ? {tx_ty, tx_data_i} : '0;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_ty    = TY_HEAD;
    if (tx_vc_ok && tx_st_q[tx_vc_i] == ST_PKT)
      tx_ty = (tx_cnt_q[tx_vc_i] != '0) ? TY_BODY : TY_TAIL;
    if (tx_vc_ok && tx_valid_i && noc_tx_ready_i) begin
      unique case (tx_ty)
        TY_HEAD: if (tx_pkt_sz_i != '0) begin
          tx_st_d[tx_vc_i]  = ST_PKT;
          tx_cnt_d[tx_vc_i] = tx_pkt_sz_i - SZ_ONE;
        end
        TY_BODY: tx_cnt_d[tx_vc_i] = tx_cnt_q[tx_vc_i] - SZ_ONE;
        default: tx_st_d[tx_vc_i] = ST_IDLE;
      endcase
    end
  end

  assign rx_vc_ok = 32'(noc_rx_vc_i) < 32'(NUM_VC);
  assign rx_ty    = flit_ty_e'(noc_rx_flit_i[FLIT_DATA_W +: 2]);
  assign rx_sz    = noc_rx_flit_i[SZ_LSB +: PKT_SZ_W];
  assign push     = noc_rx_valid_i && rdy_q;
  assign pop      = (sk_cnt_q != 2'd0) && rx_ready_i;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_rem_d = rx_rem_q;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_err   = 1'b0;
    err_set  = '0;
    if (!rx_vc_ok) begin
      in_eop = 1'b1;
    end else if (rx_st_q[noc_rx_vc_i] == ST_IDLE) begin
      if (rx_ty == TY_HEAD) begin
        in_sop = 1'b1;
        if (rx_sz == '0) in_eop = 1'b1;
        else begin
          rx_st_d[noc_rx_vc_i]  = ST_PKT;
          rx_rem_d[noc_rx_vc_i] = rx_sz;
        end
      end else in_err = 1'b1;
    end else begin
      unique case (rx_ty)
        TY_BODY: if (rx_rem_q[noc_rx_vc_i] > SZ_ONE) rx_rem_d[noc_rx_vc_i] = rx_rem_q[noc_rx_vc_i] - SZ_ONE;
                 else in_err = 1'b1;
        TY_TAIL: if (rx_rem_q[noc_rx_vc_i] == SZ_ONE) begin
                   in_eop = 1'b1;
                   rx_st_d[noc_rx_vc_i] = ST_IDLE;
                 end else in_err = 1'b1;
        default: in_err = 1'b1;
      endcase
    end
    // An erroring HEAD (only possible mid-packet) still opens a fresh packet.
    if (in_err) begin
      in_sop               = 1'b0;
      in_eop               = 1'b1;
      err_set[noc_rx_vc_i] = 1'b1;
      rx_st_d[noc_rx_vc_i] = ST_IDLE;
      if (rx_ty == TY_HEAD && rx_sz != '0) begin
        rx_st_d[noc_rx_vc_i]  = ST_PKT;
        rx_rem_d[noc_rx_vc_i] = rx_sz;
      end
    end
    if (!push) begin
      rx_st_d  = rx_st_q;
      rx_rem_d = rx_rem_q;
      err_set  = '0;
    end
  end

  assign err_d  = (err_q & ~err_clr_i) | err_set;
  assign in_ent = {noc_rx_vc_i, noc_rx_flit_i[FLIT_DATA_W-1:0], in_sop, in_eop};

  always_comb begin
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    sk_cnt_d = sk_cnt_q;
    unique case (sk_cnt_q)
      2'd0: if (push) begin
        sk0_d    = in_ent;
        sk_cnt_d = 2'd1;
      end
      2'd1: begin
        if (push && pop) sk0_d = in_ent;
        else if (push) begin
          sk1_d    = in_ent;
          sk_cnt_d = 2'd2;
        end else if (pop) sk_cnt_d = 2'd0;
      end
      default: if (pop) begin
        sk0_d    = sk1_q;
        sk_cnt_d = 2'd1;
      end
    endcase
    rdy_d = (sk_cnt_d != 2'd2);
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      tx_st_q  <= '{default: ST_IDLE};
      tx_cnt_q <= '{default: '0};
      rx_st_q  <= '{default: ST_IDLE};
      rx_rem_q <= '{default: '0};
      err_q    <= '0;
      sk0_q    <= '0;
      sk1_q    <= '0;
      sk_cnt_q <= 2'd0;
      rdy_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      rx_st_q  <= rx_st_d;
      rx_rem_q <= rx_rem_d;
      err_q    <= err_d;
      sk0_q    <= sk0_d;
      sk1_q    <= sk1_d;
      sk_cnt_q <= sk_cnt_d;
      rdy_q    <= rdy_d;
    end
  end

  assign noc_rx_ready_o = rdy_q;
  assign rx_valid_o     = (sk_cnt_q != 2'd0);
  assign rx_vc_o        = sk0_q.vc;
  assign rx_data_o      = sk0_q.data;
  assign rx_sop_o       = sk0_q.sop;
  assign rx_eop_o       = sk0_q.eop;
  assign rx_err_o       = err_q;

endmodule
